gray_ptr_counter: RTL and testbench

- Parametrised pointer engine for one side of a dual-pointer FIFO.
- Keeps a local pointer modulo 2*DEPTH, including a lap bit.
- Publishes the pointer as a registered offset-Gray code. Every increment, including wrap, changes exactly one bit.
- Decodes and validates the peer's Gray pointer, then derives level, full and empty.
- Generalises the fixed 6-entry Gray-like converters to any even depth, with counting, lap tracking and error checking.

---
 rtl/gray_ptr_counter.sv | 80 ++++++++
 tb/tb_gray_ptr_counter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/gray_ptr_counter.sv
// One side of a dual-pointer FIFO: local pointer with lap bit, published as an
// offset-Gray code, plus decode/validation of the peer pointer and level/full/empty.
module gray_ptr_counter #(
  parameter int DEPTH = 6,
  parameter int PTR_W = 3,
  parameter int MODE  = 0,
  localparam int CW   = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CW-1:0]    ptr_gray_o,
  output logic [CW-1:0]    ptr_bin_o,
  output logic [PTR_W-1:0] addr_o,
  input  logic [CW-1:0]    remote_gray_i,
  output logic [CW-1:0]    level_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             err_o
);
  localparam int M = 2 * DEPTH;
  localparam int O = (1 << PTR_W) - DEPTH;

  logic [CW-1:0] bin_q, gray_q, rbin_q, bin_nxt, rx, level_raw, addr_full;
  logic [CW:0]   diff;
  logic          valid, over, blocked;

  // Offsetting by O centres the M used codes in the reflected code, so the
  // wrap M-1 -> 0 is also a single-bit change.
  function automatic logic [CW-1:0] to_code(input logic [CW-1:0] b);
    logic [CW-1:0] x;
    x = b + CW'(O);
    return x ^ (x >> 1);
  endfunction

  always_comb begin
    rx = '0;
    rx[CW-1] = remote_gray_i[CW-1];
    for (int i = CW - 2; i >= 0; i--)
      rx[i] = rx[i+1] ^ remote_gray_i[i];
  end

  assign valid = (int'(rx) >= O) && (int'(rx) <= (1 << CW) - 1 - O);

  always_comb begin
    if (MODE == 0) diff = {1'b0, bin_q} - {1'b0, rbin_q};
    else           diff = {1'b0, rbin_q} - {1'b0, bin_q};
    if (diff[CW]) diff = diff + (CW+1)'(M);
  end

  assign level_raw = diff[CW-1:0];
  assign over      = level_raw > CW'(DEPTH);
  assign level_o   = over ? CW'(DEPTH) : level_raw;
  assign full_o    = (level_o == CW'(DEPTH));
  assign empty_o   = (level_o == '0);
  assign blocked   = (MODE == 0) ? full_o : empty_o;

  assign bin_nxt   = (bin_q == CW'(M - 1)) ? '0 : bin_q + 1'b1;
  assign addr_full = (bin_q >= CW'(DEPTH)) ? bin_q - CW'(DEPTH) : bin_q;
  assign addr_o    = addr_full[PTR_W-1:0];

  assign ptr_bin_o  = bin_q;
  assign ptr_gray_o = gray_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      gray_q <= to_code('0);
      rbin_q <= '0;
      err_o  <= 1'b0;
    end else begin
      if (inc_i && !blocked) begin
        bin_q  <= bin_nxt;
        gray_q <= to_code(bin_nxt);
      end
      if (valid) rbin_q <= rx - CW'(O);
      if (!valid || over) err_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_gray_ptr_counter.sv
// Directed bench: write side (DEPTH=6), read side (DEPTH=6) and power-of-two build (DEPTH=8).
module tb_gray_ptr_counter;
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;

  logic       a_inc, b_inc, c_inc;
  logic [3:0] a_rem, a_gray, a_bin, a_lvl, b_rem, b_gray, b_bin, b_lvl;
  logic [3:0] c_rem, c_gray, c_bin, c_lvl;
  logic [2:0] a_addr, b_addr, c_addr;
  logic       a_full, a_empty, a_err, b_full, b_empty, b_err, c_full, c_empty, c_err;

  int pass_cnt = 0, chk_cnt = 0;

  gray_ptr_counter #(.DEPTH(6), .PTR_W(3), .MODE(0)) dut_a (
    .clk(clk), .rst(rst), .inc_i(a_inc), .ptr_gray_o(a_gray), .ptr_bin_o(a_bin),
    .addr_o(a_addr), .remote_gray_i(a_rem), .level_o(a_lvl), .full_o(a_full),
    .empty_o(a_empty), .err_o(a_err));
  gray_ptr_counter #(.DEPTH(6), .PTR_W(3), .MODE(1)) dut_b (
    .clk(clk), .rst(rst), .inc_i(b_inc), .ptr_gray_o(b_gray), .ptr_bin_o(b_bin),
    .addr_o(b_addr), .remote_gray_i(b_rem), .level_o(b_lvl), .full_o(b_full),
    .empty_o(b_empty), .err_o(b_err));
  gray_ptr_counter #(.DEPTH(8), .PTR_W(3), .MODE(0)) dut_c (
    .clk(clk), .rst(rst), .inc_i(c_inc), .ptr_gray_o(c_gray), .ptr_bin_o(c_bin),
    .addr_o(c_addr), .remote_gray_i(c_rem), .level_o(c_lvl), .full_o(c_full),
    .empty_o(c_empty), .err_o(c_err));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    a_inc = 0; b_inc = 0; c_inc = 0;
    a_rem = 4'b0011; b_rem = 4'b0011; c_rem = 4'b0000;
    rst = 1;
    repeat (2) tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    chk_cnt++; if (a_gray !== 4'b0011) $display("FAIL rst_gray got %b want 0011", a_gray); else pass_cnt++;
    chk_cnt++; if (a_bin !== 4'd0) $display("FAIL rst_bin got %0d want 0", a_bin); else pass_cnt++;
    chk_cnt++; if (a_addr !== 3'd0) $display("FAIL rst_addr got %0d want 0", a_addr); else pass_cnt++;
    chk_cnt++; if (a_lvl !== 4'd0) $display("FAIL rst_level got %0d want 0", a_lvl); else pass_cnt++;
    chk_cnt++; if (a_empty !== 1'b1) $display("FAIL rst_empty got %b want 1", a_empty); else pass_cnt++;
    chk_cnt++; if (a_full !== 1'b0) $display("FAIL rst_full got %b want 0", a_full); else pass_cnt++;
    chk_cnt++; if (a_err !== 1'b0) $display("FAIL rst_err got %b want 0", a_err); else pass_cnt++;
  endtask

  task automatic test_fill();
    logic [3:0] exp_g [6];
    exp_g = '{4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      a_inc = 1;
      tick();
      if (i < 6) begin
        chk_cnt++;
        if (a_gray !== exp_g[i]) $display("FAIL fill_gray[%0d] got %b want %b", i, a_gray, exp_g[i]);
        else pass_cnt++;
      end
    end
    a_inc = 0;
    chk_cnt++; if (a_gray !== 4'b1100) $display("FAIL fill_blocked_gray got %b want 1100", a_gray); else pass_cnt++;
    chk_cnt++; if (a_bin !== 4'd6) $display("FAIL fill_blocked_bin got %0d want 6", a_bin); else pass_cnt++;
    chk_cnt++; if (a_lvl !== 4'd6) $display("FAIL fill_level got %0d want 6", a_lvl); else pass_cnt++;
    chk_cnt++; if (a_full !== 1'b1) $display("FAIL fill_full got %b want 1", a_full); else pass_cnt++;
    chk_cnt++; if (a_err !== 1'b0) $display("FAIL fill_err got %b want 0", a_err); else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [3:0] prev;
    do_reset();
    for (int k = 0; k < 30; k++) begin
      prev = a_gray;
      a_rem = a_gray;
      a_inc = 1;
      tick();
      chk_cnt++;
      if ($countones(prev ^ a_gray) != 1) $display("FAIL wrap_hamming[%0d] got %b -> %b want 1-bit step", k, prev, a_gray);
      else pass_cnt++;
      chk_cnt++;
      if (a_addr !== 3'((k + 1) % 6)) $display("FAIL wrap_addr[%0d] got %0d want %0d", k, a_addr, (k + 1) % 6);
      else pass_cnt++;
      chk_cnt++;
      if (a_lvl > 4'd1) $display("FAIL wrap_level[%0d] got %0d want 0..1", k, a_lvl);
      else pass_cnt++;
      if ((k + 1) % 12 == 0) begin
        chk_cnt++;
        if (prev !== 4'b1011 || a_gray !== 4'b0011)
          $display("FAIL wrap_edge[%0d] got %b -> %b want 1011 -> 0011", k, prev, a_gray);
        else pass_cnt++;
      end
    end
    a_inc = 0;
    chk_cnt++; if (a_err !== 1'b0) $display("FAIL wrap_err got %b want 0", a_err); else pass_cnt++;
  endtask

  task automatic test_invalid();
    do_reset();
    a_inc = 1;
    repeat (2) tick();
    a_inc = 0;
    a_rem = 4'b0000;
    tick();
    chk_cnt++; if (a_err !== 1'b1) $display("FAIL inv0000_err got %b want 1", a_err); else pass_cnt++;
    chk_cnt++; if (a_lvl !== 4'd2) $display("FAIL inv0000_level got %0d want 2", a_lvl); else pass_cnt++;
    a_rem = 4'b1000;
    tick();
    chk_cnt++; if (a_lvl !== 4'd2) $display("FAIL inv1000_level got %0d want 2", a_lvl); else pass_cnt++;
    a_rem = 4'b0011;
    repeat (2) tick();
    chk_cnt++; if (a_err !== 1'b1) $display("FAIL inv_sticky got %b want 1", a_err); else pass_cnt++;
    chk_cnt++; if (a_lvl !== 4'd2) $display("FAIL inv_valid_level got %0d want 2", a_lvl); else pass_cnt++;
    do_reset();
    chk_cnt++; if (a_err !== 1'b0) $display("FAIL inv_clear got %b want 0", a_err); else pass_cnt++;
  endtask

  task automatic test_read();
    do_reset();
    b_rem = 4'b0111;
    tick();
    chk_cnt++; if (b_lvl !== 4'd3) $display("FAIL rd_level got %0d want 3", b_lvl); else pass_cnt++;
    chk_cnt++; if (b_empty !== 1'b0) $display("FAIL rd_not_empty got %b want 0", b_empty); else pass_cnt++;
    b_inc = 1;
    repeat (3) tick();
    chk_cnt++; if (b_empty !== 1'b1) $display("FAIL rd_empty got %b want 1", b_empty); else pass_cnt++;
    tick();
    b_inc = 0;
    chk_cnt++; if (b_gray !== 4'b0111) $display("FAIL rd_blocked_gray got %b want 0111", b_gray); else pass_cnt++;
    chk_cnt++; if (b_bin !== 4'd3) $display("FAIL rd_blocked_bin got %0d want 3", b_bin); else pass_cnt++;
    chk_cnt++; if (b_err !== 1'b0) $display("FAIL rd_err got %b want 0", b_err); else pass_cnt++;
  endtask

  task automatic test_pow2();
    logic [3:0] v, g;
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      c_rem = c_gray;
      c_inc = 1;
      tick();
      v = 4'(i);
      g = v ^ (v >> 1);
      chk_cnt++;
      if (c_gray !== g) $display("FAIL p2_gray[%0d] got %b want %b", i, c_gray, g);
      else pass_cnt++;
    end
    c_inc = 0;
    do_reset();
    c_rem = 4'b0110;  // b=4 against local 0 -> raw level 12
    tick();
    chk_cnt++; if (c_lvl !== 4'd8) $display("FAIL p2_clamp_level got %0d want 8", c_lvl); else pass_cnt++;
    chk_cnt++; if (c_full !== 1'b1) $display("FAIL p2_clamp_full got %b want 1", c_full); else pass_cnt++;
    tick();
    chk_cnt++; if (c_err !== 1'b1) $display("FAIL p2_over_err got %b want 1", c_err); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_wrap();
    test_invalid();
    test_read();
    test_pow2();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
